// File: rtl/jalr_pkg.sv
// Shared types for the JALR resolve tracker.
// Entry layout, port count and tag-width helper.
package jalr_pkg;

  localparam int JALR_AW = 32;
  localparam int RESOLVE_PORTS = 3;

  typedef struct packed {
    logic [JALR_AW-1:0] pc;
    logic               pred_valid;
    logic [JALR_AW-1:0] pred_target;
  } jalr_entry_t;

  function automatic int tag_w(int tags);
    return (tags > 1) ? $clog2(tags) : 1;
  endfunction

endpackage

// File: rtl/jalr_entry_table.sv
// In-flight JALR table: one write port, three combinational reads,
// and a valid vector with per-port clear, set on alloc, and flush.
module jalr_entry_table
  import jalr_pkg::*;
#(
  parameter int TAGS = 32,
  localparam int TAG_W = tag_w(TAGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [TAG_W-1:0]         wr_tag,
  input  jalr_entry_t              wr_data,
  input  logic [RESOLVE_PORTS-1:0] clr_en,
  input  logic [TAG_W-1:0]         clr_tag [RESOLVE_PORTS],
  input  logic                     flush,
  input  logic [TAG_W-1:0]         rd_tag [RESOLVE_PORTS],
  output jalr_entry_t              rd_data [RESOLVE_PORTS],
  output logic [RESOLVE_PORTS-1:0] rd_valid
);

  jalr_entry_t     mem [TAGS];
  logic [TAGS-1:0] valid;
  logic [TAGS-1:0] valid_nxt;

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_tag] <= wr_data;
  end

  // Alloc wins over a same-cycle clear; flush beats both.
  always_comb begin
    valid_nxt = valid;
    for (int k = 0; k < RESOLVE_PORTS; k++) begin
      if (clr_en[k]) valid_nxt[clr_tag[k]] = 1'b0;
    end
    if (wr_en) valid_nxt[wr_tag] = 1'b1;
    if (flush) valid_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) valid <= '0;
    else        valid <= valid_nxt;
  end

  always_comb begin
    for (int k = 0; k < RESOLVE_PORTS; k++) begin
      rd_data[k]  = mem[rd_tag[k]];
      rd_valid[k] = valid[rd_tag[k]];
    end
  end

endmodule

// File: rtl/jalr_resolve_tracker.sv
// JALR target check against fetch-time prediction, three resolve ports.
// Optional saturating counters under JALR_TRACKER_STATS_EN.
module jalr_resolve_tracker
  import jalr_pkg::*;
#(
  parameter int ADDR_WIDTH = JALR_AW,
  parameter int TAGS = 32,
  localparam int TAG_W = tag_w(TAGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alloc_valid_i,
  input  logic [TAG_W-1:0]      alloc_tag_i,
  input  logic [ADDR_WIDTH-1:0] alloc_pc_i,
  input  logic                  alloc_pred_valid_i,
  input  logic [ADDR_WIDTH-1:0] alloc_pred_target_i,
  input  logic                  resolve_valid_i_0,
  input  logic [TAG_W-1:0]      resolve_tag_i_0,
  input  logic [ADDR_WIDTH-1:0] resolve_target_i_0,
  input  logic                  resolve_valid_i_1,
  input  logic [TAG_W-1:0]      resolve_tag_i_1,
  input  logic [ADDR_WIDTH-1:0] resolve_target_i_1,
  input  logic                  resolve_valid_i_2,
  input  logic [TAG_W-1:0]      resolve_tag_i_2,
  input  logic [ADDR_WIDTH-1:0] resolve_target_i_2,
  input  logic                  flush_i,
  output logic [ADDR_WIDTH-1:0] update_prediction_pc_0,
  output logic [ADDR_WIDTH-1:0] update_prediction_pc_1,
  output logic [ADDR_WIDTH-1:0] update_prediction_pc_2,
  output logic                  update_prediction_valid_o_0,
  output logic                  update_prediction_valid_o_1,
  output logic                  update_prediction_valid_o_2,
  output logic                  misprediction_0,
  output logic                  misprediction_1,
  output logic                  misprediction_2,
  output logic [ADDR_WIDTH-1:0] correct_pc_0,
  output logic [ADDR_WIDTH-1:0] correct_pc_1,
  output logic [ADDR_WIDTH-1:0] correct_pc_2,
  output logic                  redirect_valid_o,
  output logic [ADDR_WIDTH-1:0] redirect_pc_o,
`ifdef JALR_TRACKER_STATS_EN
  output logic [31:0]           stat_resolved_o,
  output logic [31:0]           stat_mispredicted_o,
`endif
  output logic                  resolve_err_o
);

  localparam int RP = RESOLVE_PORTS;

  logic [RP-1:0]         rv;
  logic [TAG_W-1:0]      rt  [RP];
  logic [ADDR_WIDTH-1:0] rtg [RP];
  jalr_entry_t           rd  [RP];
  logic [RP-1:0]         rd_valid;
  logic [RP-1:0]         dup, acc, bad, mis;
  jalr_entry_t           wr_data;

  assign rv     = {resolve_valid_i_2, resolve_valid_i_1, resolve_valid_i_0};
  assign rt[0]  = resolve_tag_i_0;
  assign rt[1]  = resolve_tag_i_1;
  assign rt[2]  = resolve_tag_i_2;
  assign rtg[0] = resolve_target_i_0;
  assign rtg[1] = resolve_target_i_1;
  assign rtg[2] = resolve_target_i_2;

  assign wr_data.pc          = alloc_pc_i;
  assign wr_data.pred_valid  = alloc_pred_valid_i;
  assign wr_data.pred_target = alloc_pred_target_i;

  jalr_entry_table #(.TAGS(TAGS)) u_table (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (alloc_valid_i),
    .wr_tag   (alloc_tag_i),
    .wr_data  (wr_data),
    .clr_en   (acc),
    .clr_tag  (rt),
    .flush    (flush_i),
    .rd_tag   (rt),
    .rd_data  (rd),
    .rd_valid (rd_valid)
  );

  // Higher ports carrying a tag already claimed this cycle are ignored.
  always_comb begin
    for (int k = 0; k < RP; k++) begin
      dup[k] = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (rv[j] && rt[j] == rt[k]) dup[k] = 1'b1;
      end
      acc[k] = rv[k] && !dup[k] && rd_valid[k] && !flush_i;
      bad[k] = rv[k] && !dup[k] && !rd_valid[k] && !flush_i;
      mis[k] = acc[k] &&
               (!rd[k].pred_valid || rd[k].pred_target != rtg[k]);
    end
  end

  logic [ADDR_WIDTH-1:0] rdr_pc_nxt;

  always_comb begin
    rdr_pc_nxt = '0;
    for (int k = RP - 1; k >= 0; k--) begin
      if (mis[k]) rdr_pc_nxt = rtg[k];
    end
  end

  logic [RP-1:0]         upd_v, upd_m;
  logic [ADDR_WIDTH-1:0] upd_pc [RP];
  logic [ADDR_WIDTH-1:0] upd_c  [RP];
  logic                  rdr_v;
  logic [ADDR_WIDTH-1:0] rdr_pc;
  logic                  err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_v  <= '0;
      upd_m  <= '0;
      upd_pc <= '{default: '0};
      upd_c  <= '{default: '0};
      rdr_v  <= 1'b0;
      rdr_pc <= '0;
      err    <= 1'b0;
    end else begin
      upd_v <= acc;
      upd_m <= mis;
      for (int k = 0; k < RP; k++) begin
        upd_pc[k] <= acc[k] ? rd[k].pc + ADDR_WIDTH'(4) : '0;
        upd_c[k]  <= acc[k] ? rtg[k] : '0;
      end
      rdr_v  <= |mis;
      rdr_pc <= rdr_pc_nxt;
      err    <= err | (|bad);
    end
  end

  assign update_prediction_valid_o_0 = upd_v[0];
  assign update_prediction_valid_o_1 = upd_v[1];
  assign update_prediction_valid_o_2 = upd_v[2];
  assign misprediction_0             = upd_m[0];
  assign misprediction_1             = upd_m[1];
  assign misprediction_2             = upd_m[2];
  assign update_prediction_pc_0      = upd_pc[0];
  assign update_prediction_pc_1      = upd_pc[1];
  assign update_prediction_pc_2      = upd_pc[2];
  assign correct_pc_0                = upd_c[0];
  assign correct_pc_1                = upd_c[1];
  assign correct_pc_2                = upd_c[2];
  assign redirect_valid_o            = rdr_v;
  assign redirect_pc_o               = rdr_pc;
  assign resolve_err_o               = err;

`ifdef JALR_TRACKER_STATS_EN
  function automatic logic [31:0] sat_add(logic [31:0] a, logic [1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {31'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  logic [1:0]  n_acc, n_mis;
  logic [31:0] st_res, st_mis;

  always_comb begin
    n_acc = '0;
    n_mis = '0;
    for (int k = 0; k < RP; k++) begin
      n_acc = n_acc + 2'(acc[k]);
      n_mis = n_mis + 2'(mis[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_res <= '0;
      st_mis <= '0;
    end else begin
      st_res <= sat_add(st_res, n_acc);
      st_mis <= sat_add(st_mis, n_mis);
    end
  end

  assign stat_resolved_o     = st_res;
  assign stat_mispredicted_o = st_mis;
`endif

endmodule

// File: tb/tb_jalr_resolve_tracker.sv
// Bench for jalr_resolve_tracker: directed plan, then random traffic
// against a tag-table reference model.
module tb_jalr_resolve_tracker;

  localparam int AW = 32;
  localparam int TAGS = 32;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          alloc_valid_i;
  logic [TW-1:0] alloc_tag_i;
  logic [AW-1:0] alloc_pc_i;
  logic          alloc_pred_valid_i;
  logic [AW-1:0] alloc_pred_target_i;
  logic          rv  [3];
  logic [TW-1:0] rt  [3];
  logic [AW-1:0] rtg [3];
  logic          flush_i;

  logic          upv [3];
  logic [AW-1:0] upc [3];
  logic          mp  [3];
  logic [AW-1:0] cpc [3];
  logic          rdv;
  logic [AW-1:0] rdpc;
  logic          err;
`ifdef JALR_TRACKER_STATS_EN
  logic [31:0]   st_r, st_m;
`endif

  jalr_resolve_tracker dut (
    .clk                         (clk),
    .reset                       (reset),
    .alloc_valid_i               (alloc_valid_i),
    .alloc_tag_i                 (alloc_tag_i),
    .alloc_pc_i                  (alloc_pc_i),
    .alloc_pred_valid_i          (alloc_pred_valid_i),
    .alloc_pred_target_i         (alloc_pred_target_i),
    .resolve_valid_i_0           (rv[0]),
    .resolve_tag_i_0             (rt[0]),
    .resolve_target_i_0          (rtg[0]),
    .resolve_valid_i_1           (rv[1]),
    .resolve_tag_i_1             (rt[1]),
    .resolve_target_i_1          (rtg[1]),
    .resolve_valid_i_2           (rv[2]),
    .resolve_tag_i_2             (rt[2]),
    .resolve_target_i_2          (rtg[2]),
    .flush_i                     (flush_i),
    .update_prediction_pc_0      (upc[0]),
    .update_prediction_pc_1      (upc[1]),
    .update_prediction_pc_2      (upc[2]),
    .update_prediction_valid_o_0 (upv[0]),
    .update_prediction_valid_o_1 (upv[1]),
    .update_prediction_valid_o_2 (upv[2]),
    .misprediction_0             (mp[0]),
    .misprediction_1             (mp[1]),
    .misprediction_2             (mp[2]),
    .correct_pc_0                (cpc[0]),
    .correct_pc_1                (cpc[1]),
    .correct_pc_2                (cpc[2]),
    .redirect_valid_o            (rdv),
    .redirect_pc_o               (rdpc),
`ifdef JALR_TRACKER_STATS_EN
    .stat_resolved_o             (st_r),
    .stat_mispredicted_o         (st_m),
`endif
    .resolve_err_o               (err)
  );

  // Reference model: one record per tag.
  bit            m_v  [TAGS];
  logic [AW-1:0] m_pc [TAGS];
  bit            m_pv [TAGS];
  logic [AW-1:0] m_pt [TAGS];

  logic          e_upv [3];
  logic [AW-1:0] e_upc [3];
  logic          e_mp  [3];
  logic [AW-1:0] e_cpc [3];
  logic          e_rdv;
  logic [AW-1:0] e_rdpc;
  logic          e_err;
  longint        e_sr, e_sm;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string name, logic [AW-1:0] obs, logic [AW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("upd_valid_%0d", k), AW'(upv[k]), AW'(e_upv[k]));
      chk($sformatf("upd_pc_%0d", k), upc[k], e_upc[k]);
      chk($sformatf("mispred_%0d", k), AW'(mp[k]), AW'(e_mp[k]));
      chk($sformatf("correct_pc_%0d", k), cpc[k], e_cpc[k]);
    end
    chk("redirect_valid", AW'(rdv), AW'(e_rdv));
    chk("redirect_pc", rdpc, e_rdpc);
    chk("resolve_err", AW'(err), AW'(e_err));
`ifdef JALR_TRACKER_STATS_EN
    chk("stat_resolved", st_r, e_sr[31:0]);
    chk("stat_mispredicted", st_m, e_sm[31:0]);
`endif
  endtask

  task automatic model_clear();
    for (int t = 0; t < TAGS; t++) m_v[t] = 0;
    for (int k = 0; k < 3; k++) begin
      e_upv[k] = 0; e_upc[k] = '0; e_mp[k] = 0; e_cpc[k] = '0;
    end
    e_rdv = 0; e_rdpc = '0; e_err = 0; e_sr = 0; e_sm = 0;
  endtask

  // Applies this cycle's inputs to the model, yielding next-cycle outputs.
  task automatic predict();
    bit seen [TAGS];
    int na, nm;
    na = 0; nm = 0;
    for (int t = 0; t < TAGS; t++) seen[t] = 0;
    for (int k = 0; k < 3; k++) begin
      e_upv[k] = 0; e_upc[k] = '0; e_mp[k] = 0; e_cpc[k] = '0;
    end
    e_rdv = 0; e_rdpc = '0;
    if (flush_i) begin
      for (int t = 0; t < TAGS; t++) m_v[t] = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (rv[k] && !seen[rt[k]]) begin
          seen[rt[k]] = 1;
          if (!m_v[rt[k]]) e_err = 1;
          else begin
            e_upv[k] = 1;
            e_upc[k] = m_pc[rt[k]] + 4;
            e_cpc[k] = rtg[k];
            e_mp[k]  = !m_pv[rt[k]] || (m_pt[rt[k]] != rtg[k]);
            na++;
            if (e_mp[k]) begin
              nm++;
              if (!e_rdv) begin e_rdv = 1; e_rdpc = rtg[k]; end
            end
            m_v[rt[k]] = 0;
          end
        end
      end
      if (alloc_valid_i) begin
        m_v[alloc_tag_i]  = 1;
        m_pc[alloc_tag_i] = alloc_pc_i;
        m_pv[alloc_tag_i] = alloc_pred_valid_i;
        m_pt[alloc_tag_i] = alloc_pred_target_i;
      end
    end
    e_sr = (e_sr + na > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : e_sr + na;
    e_sm = (e_sm + nm > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : e_sm + nm;
  endtask

  task automatic clr_in();
    alloc_valid_i = 0; alloc_tag_i = '0; alloc_pc_i = '0;
    alloc_pred_valid_i = 0; alloc_pred_target_i = '0;
    flush_i = 0;
    for (int k = 0; k < 3; k++) begin rv[k] = 0; rt[k] = '0; rtg[k] = '0; end
  endtask

  task automatic step();
    predict();
    @(posedge clk);
    #1;
    check_all();
    clr_in();
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    model_clear();
    check_all();
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic alloc(int tag, logic [AW-1:0] pc, bit pv, logic [AW-1:0] pt);
    alloc_valid_i = 1; alloc_tag_i = TW'(tag); alloc_pc_i = pc;
    alloc_pred_valid_i = pv; alloc_pred_target_i = pt;
    step();
  endtask

  task automatic res(int k, int tag, logic [AW-1:0] tgt);
    rv[k] = 1; rt[k] = TW'(tag); rtg[k] = tgt;
  endtask

  initial begin
    clr_in();
    model_clear();
    #1 reset = 1'b0;
    #1;
    check_all();
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check_all();

    // Correct prediction
    alloc(5, 32'h100, 1, 32'h400);
    res(0, 5, 32'h400);
    step();
    chk("t1_valid", AW'(upv[0]), 1);
    chk("t1_pc", upc[0], 32'h104);
    chk("t1_mis", AW'(mp[0]), 0);
    chk("t1_cpc", cpc[0], 32'h400);
    chk("t1_rdv", AW'(rdv), 0);

    // Missing prediction
    alloc(2, 32'h200, 0, 32'h0);
    res(1, 2, 32'h800);
    step();
    chk("t2_mis", AW'(mp[1]), 1);
    chk("t2_cpc", cpc[1], 32'h800);
    chk("t2_rdv", AW'(rdv), 1);
    chk("t2_rdpc", rdpc, 32'h800);

    // Three mispredicts at once
    alloc(10, 32'h1000, 1, 32'h1);
    alloc(11, 32'h2000, 1, 32'h1);
    alloc(12, 32'h3000, 1, 32'h1);
    res(0, 10, 32'hA00); res(1, 11, 32'hB00); res(2, 12, 32'hC00);
    step();
    chk("t3_v0", AW'(upv[0]), 1);
    chk("t3_v1", AW'(upv[1]), 1);
    chk("t3_v2", AW'(upv[2]), 1);
    chk("t3_rdpc", rdpc, 32'hA00);

    // Duplicate tag across ports
    alloc(7, 32'h700, 1, 32'h740);
    res(0, 7, 32'h740); res(2, 7, 32'h740);
    step();
    chk("t4_v0", AW'(upv[0]), 1);
    chk("t4_v2", AW'(upv[2]), 0);
    chk("t4_err0", AW'(err), 0);
    res(1, 7, 32'h740);
    step();
    chk("t4_err1", AW'(err), 1);

    // Flush discards resolves and entries
    do_reset();
    alloc(20, 32'h500, 1, 32'h600);
    alloc(21, 32'h510, 1, 32'h610);
    res(0, 20, 32'h999);
    flush_i = 1;
    step();
    chk("t5_v0", AW'(upv[0]), 0);
    chk("t5_rdv", AW'(rdv), 0);
    res(0, 21, 32'h610);
    step();
    chk("t5_err", AW'(err), 1);
    chk("t5_v0b", AW'(upv[0]), 0);

    // PC + 4 wraps
    alloc(3, 32'hFFFF_FFFC, 1, 32'h0);
    res(0, 3, 32'h10);
    step();
    chk("t6_pc", upc[0], 32'h0);
    chk("t6_mis", AW'(mp[0]), 1);

    // Random traffic on a small tag window to force collisions
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      alloc_valid_i       = 1'($urandom_range(0, 1));
      alloc_tag_i         = TW'($urandom_range(0, 7));
      alloc_pc_i          = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
      alloc_pred_valid_i  = 1'($urandom_range(0, 1));
      alloc_pred_target_i = $urandom;
      flush_i             = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < 3; k++) begin
        rv[k]  = !flush_i && ($urandom_range(0, 2) != 0);
        rt[k]  = TW'($urandom_range(0, 7));
        rtg[k] = $urandom_range(0, 1) ? m_pt[rt[k]] : $urandom;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jalr_resolve_tracker.md
Name: jalr_resolve_tracker

Overview:
- Back-end counterpart of the fetch-stage JALR target predictor.
- Records each fetched JALR's PC and predicted target by tag, then compares against the real target as the three execute ports resolve.
- Drives the predictor's three update ports and a single fetch redirect, registered one cycle after resolution.
- Sits between the fetch-stage allocation point and the three ALU/branch resolution ports.

Parameters:
- ADDR_WIDTH, 32, address/target width.
- TAGS, 32, tracked in-flight JALR entries (power of two); TAG_W = $clog2(TAGS).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- alloc_valid_i  in  1  record a JALR this cycle
- alloc_tag_i  in  TAG_W  entry to write
- alloc_pc_i  in  ADDR_WIDTH  JALR instruction PC
- alloc_pred_valid_i  in  1  predictor hit at fetch
- alloc_pred_target_i  in  ADDR_WIDTH  predicted target
- resolve_valid_i_0..2  in  1 each  execute port resolved a JALR
- resolve_tag_i_0..2  in  TAG_W each  tag of the resolving JALR
- resolve_target_i_0..2  in  ADDR_WIDTH each  actual computed target
- flush_i  in  1  pipeline flush
- update_prediction_pc_0..2  out  ADDR_WIDTH each  JALR PC + 4
- update_prediction_valid_o_0..2  out  1 each  update port active
- misprediction_0..2  out  1 each  target was wrong or missing
- correct_pc_0..2  out  ADDR_WIDTH each  actual target
- redirect_valid_o  out  1  fetch redirect request
- redirect_pc_o  out  ADDR_WIDTH  redirect target
- resolve_err_o  out  1  sticky flag: resolve hit an invalid entry

Behaviour:
- Reset: all entry valid bits 0; all outputs 0; resolve_err_o = 0. Reset is legal mid-operation and discards everything.
- Allocate:
  - On alloc_valid_i, the entry at alloc_tag_i is written and its valid bit set at the clock edge.
  - Contents become visible to resolves from the next cycle.
  - Re-allocating a valid tag overwrites it.
- Resolve (port k, when resolve_valid_i_k and the entry is valid):
  - mispredict = !pred_valid || (pred_target != resolve_target_i_k).
  - Next cycle: update_prediction_valid_o_k = 1, update_prediction_pc_k = pc + 4 (mod 2^ADDR_WIDTH), correct_pc_k = resolve_target_i_k, misprediction_k = mispredict.
  - The entry's valid bit clears at the same edge.
  - Latency is exactly 1 cycle; there is no backpressure.
- Resolve to an invalid entry: no update on that port; resolve_err_o is set and stays set until reset.
- Duplicate tag across ports in the same cycle: the lowest port wins; higher duplicates are dropped and do not set the error flag.
- Alloc and resolve of the same tag in the same cycle: the resolve sees the old contents; the allocation wins the valid bit (it stays 1).
- Redirect:
  - redirect_valid_o is registered alongside the updates.
  - It asserts if any accepted port mispredicts.
  - redirect_pc_o comes from the lowest-index mispredicting port (port 0 is oldest).
- Flush:
  - Clears all entry valid bits at the edge.
  - Resolves presented in the flush cycle produce no update and no redirect.
  - Outputs already registered in the flush cycle still present normally.
  - An alloc in the flush cycle is dropped.
- Outputs are zeroed whenever their valid is 0.

Optional Feature:
- Macro: JALR_TRACKER_STATS_EN.
- With the macro defined:
  - Adds 32-bit outputs stat_resolved_o and stat_mispredicted_o.
  - Each counts accepted resolves and mispredicts, saturating at all-ones.
  - Both reset to 0 and are unaffected by flush.
  - Increments may be 0–3 per cycle.
- Without the macro: the counter ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package jalr_pkg holds:
  - jalr_entry_t struct {pc, pred_valid, pred_target};
  - TAG_W as a function of TAGS;
  - RESOLVE_PORTS = 3.
- Sub-module jalr_entry_table: TAGS-entry register file with one write port and three combinational read ports, plus the valid vector with set/clear/flush.
- The top level holds the compare, port arbitration and output pipeline registers.

Test Plan:
- Alloc tag 5, pc 0x100, pred 0x400 valid; resolve port 0 tag 5, target 0x400 -> next cycle update_valid_0 = 1, pc_0 = 0x104, mispred_0 = 0, correct_pc_0 = 0x400, redirect_valid = 0.
- Alloc tag 2, pc 0x200, pred invalid; resolve port 1, target 0x800 -> mispred_1 = 1, correct_pc_1 = 0x800, redirect to 0x800.
- Three mispredicting resolves on ports 0/1/2 (targets 0xA00 / 0xB00 / 0xC00) in one cycle -> all three updates valid, redirect_pc = 0xA00.
- Ports 0 and 2 both resolve tag 7 -> only port 0 updates; resolve_err_o stays 0. A later resolve of tag 7 -> resolve_err_o = 1.
- Resolves with flush_i = 1 -> no update or redirect next cycle. A following resolve of a previously allocated tag sets resolve_err_o.
- Alloc tag 3, pc 0xFFFFFFFC, pred 0x0; resolve with target 0x10 -> update_pc = 0x00000000 (wrap), mispred = 1.
